// File: rtl/down_count_timer.sv
// ============================================================================
// down_count_timer
// ----------------------------------------------------------------------------
// Loadable synchronous down counter / one-shot timer.
//
// A start value is loaded through a valid/ready handshake. A start command
// then begins counting down towards zero on every cycle where en is high.
// Reaching zero produces a one-cycle tc pulse and sets the sticky done flag.
// With AUTO_RELOAD=1 the counter reloads from the stored value on the
// terminal cycle and keeps running, which makes it a periodic tick generator.
//
// Parameters:
//   WIDTH        counter / load value width in bits
//   AUTO_RELOAD  0 = one-shot (stop at zero), 1 = periodic reload
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous reset, active low
//   load_valid  in   load request, load_value valid this cycle
//   load_value  in   start / reload value
//   load_ready  out  load accepted this cycle when high (state != RUN)
//   start       in   single-cycle begin / resume command
//   stop        in   single-cycle pause command
//   en          in   count enable
//   q           out  current count (registered)
//   busy        out  high while counting (state == RUN)
//   tc          out  terminal-count pulse, one cycle wide (registered)
//   done        out  sticky one-shot completion flag
// ============================================================================
module down_count_timer #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_next;
    logic             r_tc;
    logic             w_tc_next;
    logic             r_done;
    logic             w_done_next;

    logic             w_load_ready;
    logic             w_load_accept;

    assign w_load_ready  = (r_state != ST_RUN);
    assign w_load_accept = load_valid && w_load_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_q      <= ZERO;
            r_reload <= ZERO;
            r_tc     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_q      <= w_q_next;
            r_reload <= w_reload_next;
            r_tc     <= w_tc_next;
            r_done   <= w_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_q_next      = r_q;
        w_reload_next = r_reload;
        w_tc_next     = 1'b0;      // tc is a pulse: low unless set below
        w_done_next   = r_done;

        case (r_state)
            ST_IDLE: begin
                // load > stop > start; a simultaneous stop masks start
                if (w_load_accept) begin
                    w_q_next      = load_value;
                    w_reload_next = load_value;
                    w_done_next   = 1'b0;
                end else if (stop) begin
                    // pause is a no-op while already idle
                end else if (start) begin
                    if (r_q != ZERO) begin
                        w_state_next = ST_RUN;
                    end else begin
                        // zero-length timeout: complete immediately
                        w_state_next = ST_DONE;
                        w_tc_next    = 1'b1;
                        w_done_next  = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // stop wins over a decrement, even the terminal one
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (en) begin
                    if (r_q > ONE) begin
                        w_q_next = r_q - ONE;
                    end else if (r_q == ONE) begin
                        w_tc_next = 1'b1;
                        if (AUTO_RELOAD != 0) begin
                            w_q_next = r_reload;
                        end else begin
                            w_q_next     = ZERO;
                            w_done_next  = 1'b1;
                            w_state_next = ST_DONE;
                        end
                    end
                    // q==0 cannot occur in RUN; hold rather than wrap
                end
            end

            ST_DONE: begin
                if (w_load_accept) begin
                    w_q_next      = load_value;
                    w_reload_next = load_value;
                    w_done_next   = 1'b0;
                    w_state_next  = ST_IDLE;
                end else if (start && (r_reload != ZERO)) begin
                    w_q_next     = r_reload;
                    w_done_next  = 1'b0;
                    w_state_next = ST_RUN;
                end
                // start with an empty reload value leaves DONE untouched
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign load_ready = w_load_ready;
    assign busy       = (r_state == ST_RUN);
    assign q          = r_q;
    assign tc         = r_tc;
    assign done       = r_done;

endmodule

// File: tb/tb_down_count_timer.sv
module tb_down_count_timer;

    logic       clk;
    logic       reset;

    // one-shot instance
    logic       load_valid;
    logic [3:0] load_value;
    logic       load_ready;
    logic       start;
    logic       stop;
    logic       en;
    logic [3:0] q;
    logic       busy;
    logic       tc;
    logic       done;

    // auto-reload instance
    logic       a_load_valid;
    logic [3:0] a_load_value;
    logic       a_load_ready;
    logic       a_start;
    logic       a_stop;
    logic       a_en;
    logic [3:0] a_q;
    logic       a_busy;
    logic       a_tc;
    logic       a_done;

    int errors = 0;
    int checks = 0;

    down_count_timer #(.WIDTH(4), .AUTO_RELOAD(0)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .start      (start),
        .stop       (stop),
        .en         (en),
        .q          (q),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    down_count_timer #(.WIDTH(4), .AUTO_RELOAD(1)) u_dut_ar (
        .clk        (clk),
        .reset      (reset),
        .load_valid (a_load_valid),
        .load_value (a_load_value),
        .load_ready (a_load_ready),
        .start      (a_start),
        .stop       (a_stop),
        .en         (a_en),
        .q          (a_q),
        .busy       (a_busy),
        .tc         (a_tc),
        .done       (a_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge; outputs are then sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load_valid = 1'b1;
        load_value = v;
        step();
        load_valid = 1'b0;
        $display("load %0d -> q=%0d busy=%0b done=%0b", v, q, busy, done);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        $display("start -> q=%0d busy=%0b done=%0b tc=%0b", q, busy, done, tc);
    endtask

    task automatic test_reset();
        // put the block into a non-reset state first
        do_load(4'd7);
        do_start();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({q, done, tc, busy, load_ready} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async: q=%0d done=%0b tc=%0b busy=%0b rdy=%0b, want q=0 done=0 tc=0 busy=0 rdy=1",
                     q, done, tc, busy, load_ready);
        end
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if ({q, busy, load_ready} !== {4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: q=%0d busy=%0b rdy=%0b, want 0/0/1", q, busy, load_ready);
        end
        $display("reset done: q=%0d busy=%0b", q, busy);
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_q [4];
        exp_q = '{4'd4, 4'd3, 4'd2, 4'd1};
        do_load(4'd5);
        checks++;
        if (q !== 4'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_load: q=%0d busy=%0b, want 5/0", q, busy);
        end
        do_start();
        checks++;
        if (q !== 4'd5 || busy !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_start: q=%0d busy=%0b rdy=%0b, want 5/1/0", q, busy, load_ready);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            $display("oneshot count: q=%0d tc=%0b", q, tc);
            checks++;
            if (q !== exp_q[i] || tc !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_count[%0d]: q=%0d tc=%0b, want q=%0d tc=0", i, q, tc, exp_q[i]);
            end
        end
        step();
        checks++;
        if ({q, tc, done, busy} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL oneshot_terminal: q=%0d tc=%0b done=%0b busy=%0b, want 0/1/1/0", q, tc, done, busy);
        end
        step();
        checks++;
        if ({q, tc, done} !== {4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL oneshot_after: q=%0d tc=%0b done=%0b, want 0/0/1", q, tc, done);
        end
        en = 1'b0;
    endtask

    task automatic test_en_gating();
        logic [3:0] exp_q [5];
        logic       en_pat [5];
        logic [3:0] exp_r [3];
        logic       exp_t [3];
        exp_q  = '{4'd5, 4'd5, 4'd4, 4'd4, 4'd3};
        en_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_r  = '{4'd2, 4'd1, 4'd0};
        exp_t  = '{1'b0, 1'b0, 1'b1};
        do_load(4'd6);
        checks++;
        if (q !== 4'd6 || done !== 1'b0) begin
            errors++;
            $display("FAIL gate_load_from_done: q=%0d done=%0b, want 6/0", q, done);
        end
        do_start();
        for (int i = 0; i < 5; i++) begin
            en = en_pat[i];
            step();
            $display("gated en=%0b q=%0d", en, q);
            checks++;
            if (q !== exp_q[i]) begin
                errors++;
                $display("FAIL gate_count[%0d]: q=%0d, want %0d", i, q, exp_q[i]);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        checks++;
        if ({q, busy, load_ready} !== {4'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL gate_pause: q=%0d busy=%0b rdy=%0b, want 3/0/1", q, busy, load_ready);
        end
        do_start();
        for (int i = 0; i < 3; i++) begin
            step();
            $display("resume q=%0d tc=%0b", q, tc);
            checks++;
            if (q !== exp_r[i] || tc !== exp_t[i]) begin
                errors++;
                $display("FAIL gate_resume[%0d]: q=%0d tc=%0b, want q=%0d tc=%0b", i, q, tc, exp_r[i], exp_t[i]);
            end
        end
        step();
        checks++;
        if (tc !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL gate_single_tc: tc=%0b done=%0b, want 0/1", tc, done);
        end
        en = 1'b0;
    endtask

    task automatic test_stop_terminal();
        do_load(4'd2);
        do_start();
        en = 1'b1;
        step();
        checks++;
        if (q !== 4'd1) begin
            errors++;
            $display("FAIL stopterm_pre: q=%0d, want 1", q);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        en = 1'b0;
        $display("stop on terminal: q=%0d tc=%0b busy=%0b done=%0b", q, tc, busy, done);
        checks++;
        if ({q, tc, busy, done} !== {4'd1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stopterm: q=%0d tc=%0b busy=%0b done=%0b, want 1/0/0/0", q, tc, busy, done);
        end
    endtask

    task automatic test_load_zero();
        do_load(4'd0);
        do_start();
        checks++;
        if ({q, tc, done, busy} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_start: q=%0d tc=%0b done=%0b busy=%0b, want 0/1/1/0", q, tc, done, busy);
        end
        step();
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL zero_tc_width: tc=%0b, want 0", tc);
        end
        // reload value is 0, so start from DONE changes nothing
        do_start();
        checks++;
        if ({q, tc, done, busy} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_restart: q=%0d tc=%0b done=%0b busy=%0b, want 0/0/1/0", q, tc, done, busy);
        end
    endtask

    task automatic test_load_in_run();
        do_load(4'd8);
        do_start();
        en = 1'b1;
        load_valid = 1'b1;
        load_value = 4'd3;
        step();
        load_valid = 1'b0;
        $display("load during run: q=%0d rdy=%0b", q, load_ready);
        checks++;
        if (q !== 4'd7 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_load_ignored: q=%0d rdy=%0b, want 7/0", q, load_ready);
        end
        step();
        checks++;
        if (q !== 4'd6) begin
            errors++;
            $display("FAIL run_load_after: q=%0d, want 6", q);
        end
        en = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_restart();
        logic [3:0] exp_q [4];
        exp_q = '{4'd3, 4'd2, 4'd1, 4'd0};
        do_load(4'd4);
        do_start();
        en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (done !== 1'b1 || q !== 4'd0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_first: done=%0b q=%0d rdy=%0b, want 1/0/1", done, q, load_ready);
        end
        do_start();
        checks++;
        if ({q, done, busy} !== {4'd4, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL restart_reload: q=%0d done=%0b busy=%0b, want 4/0/1", q, done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            $display("restart count q=%0d tc=%0b", q, tc);
            checks++;
            if (q !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_count[%0d]: q=%0d, want %0d", i, q, exp_q[i]);
            end
        end
        checks++;
        if (tc !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL restart_tc: tc=%0b done=%0b, want 1/1", tc, done);
        end
        en = 1'b0;
        do_load(4'd9);
        checks++;
        if ({q, done, busy} !== {4'd9, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL done_load: q=%0d done=%0b busy=%0b, want 9/0/0", q, done, busy);
        end
        // largest legal value loads unchanged
        do_load(4'd15);
        do_start();
        en = 1'b1;
        step();
        en = 1'b0;
        checks++;
        if (q !== 4'd14) begin
            errors++;
            $display("FAIL max_value: q=%0d, want 14", q);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_load(4'd4);
        do_start();
        en = 1'b1;
        step();
        step();
        checks++;
        if (q !== 4'd2) begin
            errors++;
            $display("FAIL rstmid_pre: q=%0d, want 2", q);
        end
        #2;
        reset = 1'b0;
        #1;
        $display("reset mid-run: q=%0d busy=%0b tc=%0b", q, busy, tc);
        checks++;
        if ({q, busy, tc, done, load_ready} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid: q=%0d busy=%0b tc=%0b done=%0b rdy=%0b, want 0/0/0/0/1",
                     q, busy, tc, done, load_ready);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({q, busy, tc} !== {4'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rstmid_after[%0d]: q=%0d busy=%0b tc=%0b, want 0/0/0", i, q, busy, tc);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [3:0] exp_q [6];
        logic       exp_t [6];
        logic [3:0] held;
        exp_q = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        a_load_valid = 1'b1;
        a_load_value = 4'd3;
        step();
        a_load_valid = 1'b0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        checks++;
        if (a_q !== 4'd3 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL ar_start: q=%0d busy=%0b, want 3/1", a_q, a_busy);
        end
        a_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            $display("auto-reload q=%0d tc=%0b done=%0b", a_q, a_tc, a_done);
            checks++;
            if (a_q !== exp_q[i] || a_tc !== exp_t[i] || a_done !== 1'b0 || a_busy !== 1'b1) begin
                errors++;
                $display("FAIL ar_seq[%0d]: q=%0d tc=%0b done=%0b busy=%0b, want q=%0d tc=%0b done=0 busy=1",
                         i, a_q, a_tc, a_done, a_busy, exp_q[i], exp_t[i]);
            end
        end
        step();
        held = a_q;
        a_stop = 1'b1;
        step();
        a_stop = 1'b0;
        step();
        step();
        $display("auto-reload stopped q=%0d busy=%0b", a_q, a_busy);
        checks++;
        if (a_q !== 4'd2 || held !== 4'd2 || a_busy !== 1'b0 || a_tc !== 1'b0) begin
            errors++;
            $display("FAIL ar_stop: q=%0d busy=%0b tc=%0b, want 2/0/0", a_q, a_busy, a_tc);
        end
        a_en = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        load_valid   = 1'b0;
        load_value   = 4'd0;
        start        = 1'b0;
        stop         = 1'b0;
        en           = 1'b0;
        a_load_valid = 1'b0;
        a_load_value = 4'd0;
        a_start      = 1'b0;
        a_stop       = 1'b0;
        a_en         = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        test_reset();
        test_oneshot();
        test_en_gating();
        test_stop_terminal();
        test_load_zero();
        test_load_in_run();
        test_restart();
        test_reset_mid_run();
        test_auto_reload();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
